sid_bus_writer: RTL and testbench
=================================

Name: sid_bus_writer

Overview:
- Sits directly downstream of the SPI slave in the CPLD and consumes its addr/data/write_en register-write pulses.
- Buffers writes in a small FIFO.
- Generates the SID chip's phi2 clock and drives the SID's 6502-style bus (cs_n, r/w, A[4:0], D[7:0]) with one register write per phi2 cycle.
- Also owns the SID hardware reset pulse after power-up.

Parameters:
- CLK_DIV, 8: clk cycles per phi2 half-period (16 MHz clk gives 1 MHz phi2); must be ≥2.
- FIFO_DEPTH, 8: write FIFO entries; power of two, ≥2.
- RESET_CYCLES, 16: number of phi2 periods sid_res_n is held low after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  5  SID register address from SPI slave
- data  in  8  SID register data from SPI slave
- write_en  in  1  single-cycle write strobe; push {addr,data}
- sid_phi2  out  1  SID phi2 clock
- sid_res_n  out  1  SID reset, active low
- sid_cs_n  out  1  SID chip select, active low
- sid_rw  out  1  SID R/W; 0 = write
- sid_addr  out  5  SID address bus
- sid_data  out  8  SID data bus (write-only, always driven)
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: a write was dropped
- busy  out  1  SIDRST state, or FIFO non-empty, or ACTIVE state

Behaviour:
- Reset (rst_n low, async):
  - Outputs: sid_phi2=0, sid_res_n=0, sid_cs_n=1, sid_rw=1, sid_addr=0, sid_data=0, fifo_full=0, overflow=0.
  - FIFO emptied, phase counter=0, FSM enters SIDRST.
  - Reset mid-write aborts the write immediately; cs_n returns to 1.
- Phase counter cnt:
  - Counts 0..2*CLK_DIV-1 and wraps.
  - sid_phi2 is registered, =1 when cnt≥CLK_DIV.
  - "phi2 fall" is the clk edge where cnt wraps to 0.
- FSM states SIDRST, IDLE, ACTIVE:
  - SIDRST:
    - sid_res_n=0; counts phi2 falls.
    - After RESET_CYCLES falls, set sid_res_n=1 and go to IDLE.
    - FIFO accepts pushes during SIDRST; entries are held until afterwards.
  - IDLE:
    - When cnt==1 and FIFO non-empty: pop head, load sid_addr/sid_data, set sid_rw=0 and sid_cs_n=0, go to ACTIVE.
    - Otherwise stay in IDLE.
  - ACTIVE:
    - cs_n stays low through cnt 1..2*CLK_DIV-1, covering the full phi2 high phase.
    - At phi2 fall: sid_cs_n=1, sid_rw=1, go to IDLE. The SID latches on this edge.
    - sid_addr/sid_data hold their values until the next load, which gives at least one clk of hold after the fall.
- Throughput: back-to-back writes occupy consecutive phi2 cycles. Latency from write_en to cs_n low is at most 2*CLK_DIV+1 clk once out of SIDRST.
- FIFO:
  - Order is first in, first out.
  - A push is accepted when not full, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow is set to 1; overflow clears only on rst_n.
  - fifo_full is registered from the post-update count. A simultaneous push and pop leaves the count unchanged.
- sid_data is never tri-stated; no reads are supported.

Optional Feature:
- Macro: SID_REDUNDANT_FILTER_EN.
- When defined:
  - The block keeps a 32x8 shadow register, reset to 0x00.
  - On write_en, if data equals shadow[addr], the write is discarded. It is not pushed, and overflow is not set.
  - Otherwise the write is pushed and shadow[addr] is updated only if the push is accepted.
- When undefined: no shadow storage exists, and every write_en attempts a push.

Test Plan:
- Reset release, CLK_DIV=8, RESET_CYCLES=16 → sid_phi2 period 16 clk; sid_res_n low for 256 clk after rst_n rises; cs_n stays 1; busy=1 throughout.
- Single write addr=0x18 data=0x0F after SIDRST → cs_n=0 and rw=0 from cnt=1 for 15 clk; bus shows 0x18/0x0F; cs_n rises on the phi2 fall; address and data are unchanged one clk later; busy drops after.
- 8 write_en pulses on consecutive clks (values 0x00..0x07 to addr 0..7) → fifo_full=1 after the 8th push; 8 bus cycles on 8 consecutive phi2 periods, in order; overflow=0.
- 9 pushes while full with no pop → 9th write is dropped; overflow=1 and stays 1 until rst_n; the first 8 are delivered intact. Push coinciding with a pop when full → accepted, count stays at 8.
- rst_n pulsed low while cs_n=0 → cs_n=1, rw=1, res_n=0 asynchronously; FIFO is empty after release; no further bus cycle occurs until SIDRST completes.
- With SID_REDUNDANT_FILTER_EN defined: addr=4 data=0x12 written twice, then data=0x00 to addr=5 → exactly one bus cycle (0x04/0x12). Without the macro → three bus cycles.

Source files
------------

// File: rtl/sid_bus_writer_if.sv
// sid_bus_writer_if: SPI-side register-write port plus the SID bus and status lines of sid_bus_writer.
interface sid_bus_writer_if;
  logic [4:0] addr;
  logic [7:0] data;
  logic       write_en;
  logic       sid_phi2;
  logic       sid_res_n;
  logic       sid_cs_n;
  logic       sid_rw;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       fifo_full;
  logic       overflow;
  logic       busy;
  modport master (
    output addr, data, write_en,
    input  sid_phi2, sid_res_n, sid_cs_n, sid_rw, sid_addr, sid_data, fifo_full, overflow, busy
  );
  modport slave (
    input  addr, data, write_en,
    output sid_phi2, sid_res_n, sid_cs_n, sid_rw, sid_addr, sid_data, fifo_full, overflow, busy
  );
endinterface

// File: rtl/sid_bus_writer.sv
// sid_bus_writer: FIFO-buffered SPI register writes replayed on the SID bus, one per phi2 cycle, plus SID reset.
// Define SID_REDUNDANT_FILTER_EN to drop writes whose data already matches a shadow copy of the register.
module sid_bus_writer #(
  parameter int CLK_DIV      = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int RESET_CYCLES = 16
) (
  input logic             clk,
  input logic             rst_n,
  sid_bus_writer_if.slave bus
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [1:0] {SIDRST, IDLE, ACTIVE} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_res_cnt;
  logic [AW:0]   r_count, w_count_nxt;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [12:0]   r_mem [FIFO_DEPTH];
  logic          r_phi2, r_res_n, r_cs_n, r_rw, r_full, r_ovf;
  logic [4:0]    r_addr;
  logic [7:0]    r_data;
  logic          w_wrap, w_res_done, w_pop, w_push_req, w_push;

  assign w_wrap      = r_cnt == CW'(2 * CLK_DIV - 1);
  assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
  assign w_res_done  = r_res_cnt == RW'(RESET_CYCLES - 1);
  // Loading on the edge that takes cnt to 1 keeps cs_n low for cnt 1..2*CLK_DIV-1.
  assign w_pop       = r_state == IDLE && r_cnt == '0 && r_count != '0;
  assign w_push      = w_push_req && (r_count != (AW+1)'(FIFO_DEPTH) || w_pop);
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

`ifdef SID_REDUNDANT_FILTER_EN
  logic [7:0] r_shadow [32];
  assign w_push_req = bus.write_en && r_shadow[bus.addr] != bus.data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 32; i++) r_shadow[i] <= '0;
    else if (w_push) r_shadow[bus.addr] <= bus.data;
  end
`else
  assign w_push_req = bus.write_en;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == SIDRST) w_state_nxt = (w_wrap && w_res_done) ? IDLE : SIDRST;
    else if (r_state == IDLE) w_state_nxt = w_pop ? ACTIVE : IDLE;
    else w_state_nxt = w_wrap ? IDLE : ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SIDRST;
      r_cnt     <= '0;
      r_res_cnt <= '0;
      r_phi2    <= 1'b0;
      r_res_n   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_data    <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phi2  <= w_cnt_nxt >= CW'(CLK_DIV);
      if (r_state == SIDRST && w_wrap) r_res_cnt <= r_res_cnt + RW'(1);
      if (r_state == SIDRST && w_state_nxt == IDLE) r_res_n <= 1'b1;
      if (w_pop) begin
        r_cs_n           <= 1'b0;
        r_rw             <= 1'b0;
        {r_addr, r_data} <= r_mem[r_rptr];
        r_rptr           <= r_rptr + AW'(1);
      end else if (r_state == ACTIVE && w_wrap) begin
        r_cs_n <= 1'b1;
        r_rw   <= 1'b1;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= w_count_nxt == (AW+1)'(FIFO_DEPTH);
      r_ovf   <= r_ovf | (w_push_req & ~w_push);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.addr, bus.data};
  end

  assign bus.sid_phi2  = r_phi2;
  assign bus.sid_res_n = r_res_n;
  assign bus.sid_cs_n  = r_cs_n;
  assign bus.sid_rw    = r_rw;
  assign bus.sid_addr  = r_addr;
  assign bus.sid_data  = r_data;
  assign bus.fifo_full = r_full;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = r_state != IDLE || r_count != '0;
endmodule

// File: tb/tb_sid_bus_writer.sv
// tb_sid_bus_writer: randomized bench for sid_bus_writer checked against a cycle-level model built from
// slot arithmetic (one write slot per phi2 period after the reset window) and a queue for the FIFO.
module tb_sid_bus_writer;
  localparam int CLK_DIV = 8, FIFO_DEPTH = 8, RESET_CYCLES = 16;
  localparam int P  = 2 * CLK_DIV;
  localparam int RD = RESET_CYCLES * P;
`ifdef SID_REDUNDANT_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b1;
  int checks = 0, errors = 0;
  sid_bus_writer_if bus();
  sid_bus_writer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .RESET_CYCLES(RESET_CYCLES))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [19:0] obs_vec;
  assign obs_vec = {bus.sid_phi2, bus.sid_res_n, bus.sid_cs_n, bus.sid_rw, bus.sid_addr, bus.sid_data,
                    bus.fifo_full, bus.overflow, bus.busy};

  int          n = 0, act_end = -1;
  logic [12:0] q[$], m_log[$], obs_q[$];
  logic [4:0]  m_addr = '0;
  logic [7:0]  m_data = '0;
  logic        m_ovf = 1'b0, prev_cs = 1'b1;
  logic [7:0]  m_shadow [32];

  function automatic logic [19:0] exp_vec();
    logic c;
    c = !(n <= act_end);
    return {((n % P) >= CLK_DIV), (n >= RD), c, c, m_addr, m_data, (q.size() == FIFO_DEPTH), m_ovf,
            ((n < RD) || (q.size() != 0) || !c)};
  endfunction

  task automatic model_reset();
    n = 0; act_end = -1; q.delete(); m_addr = '0; m_data = '0; m_ovf = 1'b0;
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
  endtask

  task automatic tick(input logic we, input logic [4:0] a, input logic [7:0] d);
    bus.write_en = we; bus.addr = a; bus.data = d;
    @(posedge clk);
    n++;
    if (n % P == 1 && n > RD && q.size() != 0) begin
      {m_addr, m_data} = q.pop_front();
      act_end = n + P - 2;
      m_log.push_back({m_addr, m_data});
    end
    if (we && !(FILT != 0 && m_shadow[a] == d)) begin
      if (q.size() < FIFO_DEPTH) begin
        q.push_back({a, d});
        m_shadow[a] = d;
      end else m_ovf = 1'b1;
    end
    #1;
    if (prev_cs && !bus.sid_cs_n) obs_q.push_back({bus.sid_addr, bus.sid_data});
    prev_cs = bus.sid_cs_n;
  endtask

  task automatic test_reset();
    bus.write_en = 1'b0; bus.addr = '0; bus.data = '0;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++; if (obs_vec !== 20'h30001) begin errors++; $display("FAIL reset_values got=%h exp=%h", obs_vec, 20'h30001); end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 1; k <= RD + 2; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL reset_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
      if (k == CLK_DIV || k == P) begin
        checks++; if (bus.sid_phi2 !== (k == CLK_DIV)) begin errors++; $display("FAIL phi2_edge k=%0d got=%b", k, bus.sid_phi2); end
      end
      if (k == RD - 1 || k == RD) begin
        checks++; if (bus.sid_res_n !== (k == RD)) begin errors++; $display("FAIL res_n_release k=%0d got=%b", k, bus.sid_res_n); end
      end
    end
  endtask

  task automatic test_single();
    int low = 0;
    bit seen = 1'b0;
    obs_q.delete(); m_log.delete();
    while (n % P != 5) tick(1'b0, '0, '0);
    tick(1'b1, 5'h18, 8'h0F);
    for (int k = 0; k < 2 * P + 4; k++) begin
      logic was;
      was = bus.sid_cs_n;
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL single_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
      if (!bus.sid_cs_n) begin
        low++;
        if (!seen) begin
          seen = 1'b1;
          checks++; if ({bus.sid_rw, bus.sid_addr, bus.sid_data} !== {1'b0, 5'h18, 8'h0F}) begin errors++; $display("FAIL single_load got=%b/%h/%h exp=0/18/0f", bus.sid_rw, bus.sid_addr, bus.sid_data); end
        end
      end
      if (!was && bus.sid_cs_n) begin
        checks++; if ({bus.sid_phi2, bus.sid_addr, bus.sid_data} !== {1'b0, 5'h18, 8'h0F}) begin errors++; $display("FAIL single_release got=%b/%h/%h exp=0/18/0f", bus.sid_phi2, bus.sid_addr, bus.sid_data); end
      end
    end
    checks++; if (low != P - 1) begin errors++; $display("FAIL single_cs_width got=%0d exp=%0d", low, P - 1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_burst();
    obs_q.delete(); m_log.delete();
    while (n % P != 1) tick(1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 5'(i), 8'(i));
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL burst_push n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (bus.fifo_full !== (FILT == 0)) begin errors++; $display("FAIL burst_full got=%b", bus.fifo_full); end
    for (int k = 0; k < 9 * P; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL burst_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (obs_q.size() != 8 - FILT) begin errors++; $display("FAIL burst_count got=%0d exp=%0d", obs_q.size(), 8 - FILT); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== {5'(i + FILT), 8'(i + FILT)}) begin errors++; $display("FAIL burst_order i=%0d got=%h exp=%h", i, obs_q[i], {5'(i + FILT), 8'(i + FILT)}); end
    end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_overflow();
    obs_q.delete(); m_log.delete();
    while (n % P != 1) tick(1'b0, '0, '0);
    for (int i = 0; i < 9; i++) tick(1'b1, 5'(i), 8'(8'h40 + i));
    checks++; if ({bus.fifo_full, bus.overflow} !== 2'b11) begin errors++; $display("FAIL ovf_set got=%b exp=11", {bus.fifo_full, bus.overflow}); end
    for (int k = 0; k < 9 * P; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL ovf_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== {5'(i), 8'(8'h40 + i)}) begin errors++; $display("FAIL ovf_data i=%0d got=%h", i, obs_q[i]); end
    end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    obs_q.delete(); m_log.delete();
    while (n % P != 1) tick(1'b0, '0, '0);
    for (int i = 0; i < 8; i++) tick(1'b1, 5'(i), 8'(8'h60 + i));
    while (n % P != 0) tick(1'b0, '0, '0);
    tick(1'b1, 5'd8, 8'h70);
    checks++; if ({bus.fifo_full, bus.sid_cs_n} !== 2'b10) begin errors++; $display("FAIL push_pop_full got=%b exp=10", {bus.fifo_full, bus.sid_cs_n}); end
    for (int k = 0; k < 10 * P; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL push_pop_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (obs_q.size() != 9) begin errors++; $display("FAIL push_pop_count got=%0d exp=9", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== (i < 8 ? {5'(i), 8'(8'h60 + i)} : {5'd8, 8'h70})) begin errors++; $display("FAIL push_pop_data i=%0d got=%h", i, obs_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    obs_q.delete(); m_log.delete();
    while (n % P != 1) tick(1'b0, '0, '0);
    tick(1'b1, 5'd3, 8'h33); tick(1'b1, 5'd9, 8'h99); tick(1'b1, 5'd10, 8'hAA);
    for (int k = 0; k < 3 * P && bus.sid_cs_n; k++) tick(1'b0, '0, '0);
    checks++; if (bus.sid_cs_n !== 1'b0) begin errors++; $display("FAIL mid_reset_wait cs_n=%b exp=0", bus.sid_cs_n); end
    repeat (3) tick(1'b0, '0, '0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if ({bus.sid_cs_n, bus.sid_rw, bus.sid_res_n, bus.fifo_full, bus.overflow} !== 5'b11000) begin errors++; $display("FAIL mid_reset_async got=%b exp=11000", {bus.sid_cs_n, bus.sid_rw, bus.sid_res_n, bus.fifo_full, bus.overflow}); end
    checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL mid_reset_vec got=%h exp=%h", obs_vec, exp_vec()); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    prev_cs = bus.sid_cs_n;
    tick(1'b1, 5'd1, 8'h11); tick(1'b1, 5'd2, 8'h22);
    for (int k = 0; k < RD + 4 * P; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL mid_reset_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL mid_reset_count got=%0d exp=3", obs_q.size()); end
    checks++; if ({obs_q[0], obs_q[1], obs_q[2]} !== {5'd3, 8'h33, 5'd1, 8'h11, 5'd2, 8'h22}) begin errors++; $display("FAIL mid_reset_data got=%h %h %h", obs_q[0], obs_q[1], obs_q[2]); end
  endtask

  task automatic test_filter();
    obs_q.delete(); m_log.delete();
    tick(1'b1, 5'd4, 8'h12); tick(1'b1, 5'd4, 8'h12); tick(1'b1, 5'd5, 8'h00);
    for (int k = 0; k < 5 * P; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL filter_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (obs_q.size() != (FILT != 0 ? 1 : 3)) begin errors++; $display("FAIL filter_count got=%0d exp=%0d", obs_q.size(), FILT != 0 ? 1 : 3); end
    checks++; if (obs_q[0] !== {5'd4, 8'h12}) begin errors++; $display("FAIL filter_first got=%h exp=%h", obs_q[0], {5'd4, 8'h12}); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL filter_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_random();
    obs_q.delete(); m_log.delete();
    for (int k = 0; k < 1200; k++) begin
      tick($urandom_range(0, ((k / 150) % 2 != 0) ? 2 : 24) == 0, 5'($urandom), 8'($urandom_range(0, 3)));
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL random_seq n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    for (int k = 0; k < (FIFO_DEPTH + 2) * P; k++) begin
      tick(1'b0, '0, '0);
      checks++; if (obs_vec !== exp_vec()) begin errors++; $display("FAIL random_drain n=%0d got=%h exp=%h", n, obs_vec, exp_vec()); end
    end
    checks++; if (obs_q.size() != m_log.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), m_log.size()); end
    for (int i = 0; i < obs_q.size() && i < m_log.size(); i++) begin
      checks++; if (obs_q[i] !== m_log[i]) begin errors++; $display("FAIL random_data i=%0d got=%h exp=%h", i, obs_q[i], m_log[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_mid_reset();
    test_filter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
